// File: rtl/abs_diff_pkg.sv
// Shared types and width helpers for the sum-of-absolute-differences engine.
// Pure declarations: no latency, no flow control.
package abs_diff_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    // Count must represent LEN itself, hence LEN+1 codes.
    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

    function automatic int sum_w(input int n, input int len);
        return n + cnt_w(len);
    endfunction

endpackage

// File: rtl/abs_diff_accum_if.sv
// Operand stream in, frame result out; both valid/ready.
// Master drives operands and result-ready; slave is the engine.
interface abs_diff_accum_if #(
    parameter int N   = 8,
    parameter int LEN = 16
);
    import abs_diff_pkg::*;

    localparam int SW = sum_w(N, LEN);
    localparam int CW = cnt_w(LEN);

    logic          in_vld;
    logic          in_rdy;
    logic [N-1:0]  a_dat;
    logic [N-1:0]  b_dat;
    logic          out_vld;
    logic          out_rdy;
    logic [SW-1:0] sum_dat;
    logic [N-1:0]  maxd_dat;
    logic [CW-1:0] ge_cnt_dat;
    logic [CW-1:0] idx_dat;

    modport master (
        output in_vld, a_dat, b_dat, out_rdy,
        input  in_rdy, out_vld, sum_dat, maxd_dat, ge_cnt_dat, idx_dat
    );

    modport slave (
        input  in_vld, a_dat, b_dat, out_rdy,
        output in_rdy, out_vld, sum_dat, maxd_dat, ge_cnt_dat, idx_dat
    );

endinterface

// File: rtl/abs_diff_cla.sv
// Flat carry-lookahead adder: s = a + b + cin, carry-out not exported.
// Combinational, zero latency, no flow control.
module abs_diff_cla #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] c;
    logic         acc;
    logic         pp;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Each carry expanded directly from generate/propagate terms.
    always_comb begin
        c    = '0;
        c[0] = cin_i;
        acc  = 1'b0;
        pp   = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin_i);
        end
    end

    assign s_o = p ^ c;

endmodule

// File: rtl/abs_diff_core.sv
// |A-B| and A>=B from one subtracting adder plus one conditional-negate adder.
// Combinational, zero latency, no flow control.
module abs_diff_core #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] d_o,
    output logic         ge_o
);
    logic [N:0]   diff_ext;
    logic [N-1:0] neg_in;

    // One extra bit turns the top sum bit into the borrow, so A>=B needs no carry port.
    abs_diff_cla #(.W(N + 1)) u_sub (
        .a_i   ({1'b0, a_i}),
        .b_i   (~{1'b0, b_i}),
        .cin_i (1'b1),
        .s_o   (diff_ext)
    );

    assign ge_o   = ~diff_ext[N];
    assign neg_in = diff_ext[N-1:0] ^ {N{~ge_o}};

    abs_diff_cla #(.W(N)) u_neg (
        .a_i   (neg_in),
        .b_i   ('0),
        .cin_i (~ge_o),
        .s_o   (d_o)
    );

endmodule

// File: rtl/abs_diff_accum.sv
// Per-frame SAD, max diff and A>=B count over LEN pairs; result valid the cycle after the last accept.
// Input stalls (in_rdy=0) while a result waits in DONE; clr_i aborts the frame from any state.
module abs_diff_accum
    import abs_diff_pkg::*;
#(
    parameter int N   = 8,
    parameter int LEN = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    abs_diff_accum_if.slave  bus
);
    localparam int SW = sum_w(N, LEN);
    localparam int CW = cnt_w(LEN);

    state_e        state_q, state_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [N-1:0]  max_q, max_d;
    logic [CW-1:0] ge_q, ge_d;
    logic [CW-1:0] idx_q, idx_d;

    logic [N-1:0]  d;
    logic          ge;
    logic          accept;

    abs_diff_core #(.N(N)) u_core (
        .a_i  (bus.a_dat),
        .b_i  (bus.b_dat),
        .d_o  (d),
        .ge_o (ge)
    );

    assign accept = (state_q == ACCUM) && bus.in_vld;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        max_d   = max_q;
        ge_d    = ge_q;
        idx_d   = idx_q;
        if (clr_i || ((state_q == DONE) && bus.out_rdy)) begin
            state_d = ACCUM;
            sum_d   = '0;
            max_d   = '0;
            ge_d    = '0;
            idx_d   = '0;
        end else if (accept) begin
            sum_d = sum_q + {{(SW-N){1'b0}}, d};
            max_d = (d > max_q) ? d : max_q;
            ge_d  = ge_q + {{(CW-1){1'b0}}, ge};
            idx_d = idx_q + 1'b1;
            if (idx_q == CW'(LEN - 1)) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            max_q   <= '0;
            ge_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            ge_q    <= ge_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake outputs decode the state register only.
    assign bus.in_rdy     = (state_q == ACCUM);
    assign bus.out_vld    = (state_q == DONE);
    assign bus.sum_dat    = sum_q;
    assign bus.maxd_dat   = max_q;
    assign bus.ge_cnt_dat = ge_q;
    assign bus.idx_dat    = idx_q;

endmodule
